gpo_disp_driver: RTL and testbench
==================================

GPO_DISP_DRIVER -- requirements
Module: gpo_disp_driver

Interface
REQ-001 Parameter WIDTH, default 32: width of the displayed value; fixed at 32 in this release.
REQ-002 Parameter SCAN_DIV, default 1024: clock cycles each digit is held on the display; legal range 2..65535.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 VAL  input  WIDTH  value to display; driven by gpo1 of the GPIO block.
REQ-006 MODE  input  1  display mode: 0 = hex, 1 = decimal.
REQ-007 BLANK_LZ  input  1  1 = blank leading zeros.
REQ-008 LEDSEL  output  8  digit anode enables, active-low; bit i selects digit i; digit 0 is least significant.
REQ-009 LEDOUT  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always off (1).
REQ-010 BUSY  output  1  high while a decimal conversion is in progress.

Function
REQ-011 The block SHALL keep a display register DREG of 8 nibbles plus a per-digit blank flag; scanning reads only DREG.
REQ-012 Converter FSM states SHALL be IDLE, SHIFT and LOAD.
- IDLE -> SHIFT when VAL or MODE differs from the last latched pair (SRC_VAL, SRC_MODE).
- Entering SHIFT latches SRC_VAL = VAL and SRC_MODE = MODE.
REQ-013 In hex mode, SHIFT SHALL last 1 cycle, then go to LOAD; DREG nibble i = SRC_VAL[4i+3:4i].
REQ-014 In decimal mode, SHIFT SHALL run the shift-add-3 (double-dabble) algorithm.
- Exactly 32 cycles, 40-bit BCD accumulator, MSB of SRC_VAL first.
- On each cycle, before the shift, add 3 to every BCD nibble >= 5.
- Then go to LOAD.
REQ-015 LOAD SHALL last 1 cycle, update DREG atomically and return to IDLE.
- Decimal overflow: if SRC_VAL > 99,999,999 (BCD digits 8 or 9 nonzero), all 8 digits SHALL show 'E'.
REQ-016 VAL/MODE changes during SHIFT SHALL NOT disturb the conversion in progress.
- On return to IDLE the comparison is repeated; a new conversion starts on the next cycle if the inputs still differ.
REQ-017 BUSY SHALL be 1 in SHIFT and LOAD, 0 in IDLE.
- Decimal update latency: 34 cycles from the change to the new DREG (1 detect + 32 shift + 1 load).
- Hex update latency: 3 cycles.
REQ-018 Leading-zero blanking: with BLANK_LZ=1, zero digits above the most significant nonzero digit SHALL be blanked (LEDOUT = 0xFF).
- Digit 0 is never blanked.
- BLANK_LZ is evaluated live during scanning, not latched.
REQ-019 A 16-bit prescaler SHALL count 0..SCAN_DIV-1 and wrap.
- On each wrap, the 3-bit digit index advances 0,1,...,7 and wraps 7 -> 0.
REQ-020 LEDSEL SHALL be ~(1 << index); LEDOUT SHALL be the active-low glyph for DREG[index].
- Glyph values: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, blank=FF.
REQ-021 LEDSEL and LEDOUT SHALL be registered, so they change on the same edge as the index and never glitch between digits.

Reset
REQ-022 When RST=1 at a clock edge:
- FSM returns to IDLE.
- SRC_VAL = 0, SRC_MODE = 0, DREG = all zeros, prescaler = 0, index = 0.
- LEDSEL = 0xFE, LEDOUT = 0xC0, BUSY = 0.
REQ-023 Reset during SHIFT SHALL abandon the conversion; DREG stays zeros.
- The first post-reset comparison uses SRC_VAL = 0, SRC_MODE = 0.
REQ-024 After reset with VAL=0 and MODE=0, no conversion SHALL start.

Verification
REQ-025 Hex, SCAN_DIV=4: VAL=0x12345678, MODE=0.
- After 3 cycles, over 32 cycles, LEDSEL steps FE,FD,...,7F.
- LEDOUT steps 80,F8,82,92,99,B0,A4,F9.
REQ-026 Decimal: VAL=12345678, MODE=1.
- BUSY is high for exactly 33 cycles.
- DREG then reads 1,2,3,4,5,6,7,8 (MSD to LSD); digit 0 shows 80.
REQ-027 Overflow: VAL=100,000,000, MODE=1 -> all digits show 86.
- Then VAL=99,999,999 -> all digits show 90.
REQ-028 Blanking: VAL=42, MODE=1, BLANK_LZ=1.
- Digits 7..2 show FF, digit 1 shows 99, digit 0 shows A4.
- With VAL=0, only digit 0 shows C0.
REQ-029 Mid-conversion change: VAL=5 (decimal), then VAL=7 on cycle 10 of SHIFT.
- Digit 0 shows 92 first.
- A second BUSY pulse follows; final digit 0 shows F8.
REQ-030 Reset: assert RST on SHIFT cycle 15 of a conversion of VAL=999.
- Next cycle: BUSY=0, LEDSEL=FE, LEDOUT=C0.
- With VAL still 999, a fresh conversion starts after RST falls.

Source files
------------

// File: rtl/gpo_disp_driver_if.sv
// gpo_disp_driver_if: bundles the value/mode inputs and display outputs of the display driver.
// Latency: none, wiring only.
// Backpressure: none; master drives val/mode/blank_lz, slave drives ledsel/ledout/busy.
interface gpo_disp_driver_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] val;       // value to display
   logic             mode;      // 0 = hex, 1 = decimal
   logic             blank_lz;  // 1 = blank leading zeros
   logic [7:0]       ledsel;    // digit anode enables, active-low
   logic [7:0]       ledout;    // segments {dp,g,f,e,d,c,b,a}, active-low
   logic             busy;      // conversion in progress

   modport master (output val, mode, blank_lz, input ledsel, ledout, busy);
   modport slave  (input val, mode, blank_lz, output ledsel, ledout, busy);
endinterface

// File: rtl/gpo_disp_driver.sv
// gpo_disp_driver: converts a 32-bit value to 8 hex or decimal digits and scans them onto a 7-segment display.
// Latency: display register updates 3 cycles (hex) or 34 cycles (decimal) after val/mode change; scan outputs registered.
// Backpressure: none; val/mode changes during a conversion are re-evaluated once it completes.
// Ports: clk; rst (synchronous, active-high); bus (slave): val, mode, blank_lz in; ledsel, ledout, busy out.
module gpo_disp_driver #(
   parameter int WIDTH    = 32,
   parameter int SCAN_DIV = 1024
) (
   input  logic             clk,
   input  logic             rst,
   gpo_disp_driver_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] src_val;
   logic             src_mode;
   logic [WIDTH-1:0] shreg;      // working copy of src_val, consumed MSB first
   logic [CNT_W-1:0] cnt;
   logic [39:0]      bcd, bcd_adj;
   logic [31:0]      dreg, dreg_n;
   logic [7:0]       lz, lz_n;   // per-digit "leading zero" flag, bit 0 always clear
   logic             lz_seen;
   logic             start;
   logic             busy;

   logic [15:0]      presc;
   logic [2:0]       idx, idx_n;
   logic             wrap;
   logic [7:0]       ledsel_q, ledout_q;

   function automatic logic [7:0] glyph(input logic [3:0] d, input logic blank);
      logic [7:0] g;
      g = 8'hFF;
      case (d)
         4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
         4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
         4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
         4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  4'hF: g = 8'h8E;
         default: g = 8'hFF;
      endcase
      return blank ? 8'hFF : g;
   endfunction

   assign start = (bus.val != src_val) || (bus.mode != src_mode);

   // ---------------- converter FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = SHIFT;
         // hex needs a single pass; decimal runs one cycle per source bit
         SHIFT:   if (!src_mode || cnt == CNT_W'(WIDTH - 1)) state_n = LOAD;
         LOAD:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // Double-dabble correction: any BCD digit >= 5 would carry past 9 when doubled.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 10; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Value written to the display register on LOAD; digits 8/9 nonzero means it does not fit.
   always_comb begin
      if (src_mode) dreg_n = (bcd[39:32] != 8'd0) ? {8{4'hE}} : bcd[31:0];
      else          dreg_n = 32'(src_val);
      lz_n    = 8'h00;
      lz_seen = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         lz_seen  = lz_seen | (dreg_n[4*i +: 4] != 4'd0);
         lz_n[i]  = ~lz_seen;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_val  <= '0;
         src_mode <= 1'b0;
         shreg    <= '0;
         cnt      <= '0;
         bcd      <= '0;
         dreg     <= '0;
         lz       <= 8'hFE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_val  <= bus.val;
                  src_mode <= bus.mode;
                  shreg    <= bus.val;
                  cnt      <= '0;
                  bcd      <= '0;
               end
            end
            SHIFT: begin
               bcd   <= (bcd_adj << 1) | 40'(shreg[WIDTH-1]);
               shreg <= shreg << 1;
               cnt   <= cnt + 1'b1;
            end
            LOAD: begin
               dreg <= dreg_n;
               lz   <= lz_n;
            end
            default: ;
         endcase
      end
   end

   // ---------------- digit scanner ----------------
   assign wrap  = (presc == 16'(SCAN_DIV - 1));
   assign idx_n = wrap ? idx + 3'd1 : idx;

   // Outputs are driven from the next index so select and segments move on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         idx      <= '0;
         ledsel_q <= 8'hFE;
         ledout_q <= 8'hC0;
      end else begin
         presc    <= wrap ? 16'd0 : presc + 16'd1;
         idx      <= idx_n;
         ledsel_q <= ~(8'd1 << idx_n);
         ledout_q <= glyph(dreg[{idx_n, 2'b00} +: 4], bus.blank_lz & lz[idx_n]);
      end
   end

   assign bus.ledsel = ledsel_q;
   assign bus.ledout = ledout_q;
   assign bus.busy   = busy;
endmodule

// File: tb/tb_gpo_disp_driver.sv
// tb_gpo_disp_driver: directed and random stimulus for gpo_disp_driver against a behavioural display model.
// Latency: model tracks conversion time as a countdown of busy cycles.
// Backpressure: none.
module tb_gpo_disp_driver;
   localparam int SDIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   gpo_disp_driver_if #(.WIDTH(32)) bus ();

   gpo_disp_driver #(.WIDTH(32), .SCAN_DIV(SDIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // ---------------- behavioural model ----------------
   int          m_busy = 0;        // busy cycles still to come
   logic [31:0] m_src_val = '0;
   logic        m_src_mode = 1'b0;
   int          m_dig [8];
   bit          m_lz  [8];
   longint      m_cyc = 0;
   int          m_idx = 0;
   logic [7:0]  m_ledsel = 8'hFE;
   logic [7:0]  m_ledout = 8'hC0;

   task automatic model_load(input logic [31:0] v, input logic md);
      longint x, p, above;
      x = longint'(v);
      p = 1;
      for (int i = 0; i < 8; i++) begin
         if (md) begin
            if (x > 99999999) begin
               m_dig[i] = 14;
               above    = 1;
            end else begin
               m_dig[i] = int'((x / p) % 10);
               above    = x / p;
            end
            p = p * 10;
         end else begin
            m_dig[i] = int'((x >> (4 * i)) & 15);
            above    = x >> (4 * i);
         end
         m_lz[i] = (i > 0) && (above == 0);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_src_val = '0; m_src_mode = 1'b0;
         for (int i = 0; i < 8; i++) begin m_dig[i] = 0; m_lz[i] = (i > 0); end
         m_cyc = 0; m_idx = 0; m_ledsel = 8'hFE; m_ledout = 8'hC0;
      end else begin
         m_cyc++;
         m_idx    = int'((m_cyc / SDIV) % 8);
         m_ledsel = 8'hFF ^ (8'd1 << m_idx);
         m_ledout = (bus.blank_lz && m_lz[m_idx]) ? 8'hFF : GLYPH[m_dig[m_idx]];
         if (m_busy == 0) begin
            if (bus.val != m_src_val || bus.mode != m_src_mode) begin
               m_src_val  = bus.val;
               m_src_mode = bus.mode;
               m_busy     = bus.mode ? 33 : 2;
            end
         end else begin
            m_busy--;
            if (m_busy == 0) model_load(m_src_val, m_src_mode);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      chk("busy",   32'(bus.busy),   32'(m_busy != 0));
      chk("ledsel", 32'(bus.ledsel), 32'(m_ledsel));
      chk("ledout", 32'(bus.ledout), 32'(m_ledout));
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [31:0] v, input logic md);
      @(negedge clk);
      bus.val  = v;
      bus.mode = md;
   endtask

   task automatic busy_len(output int n);
      int g;
      n = 0; g = 0;
      while (!bus.busy && g < 10) begin tick(); g++; end
      while (bus.busy && n < 100) begin n++; tick(); end
   endtask

   task automatic check_digit(input int i, input logic [7:0] exp, input string name);
      logic [7:0] sel;
      int g;
      sel = ~(8'd1 << i);
      g = 0;
      do begin tick(); g++; end while (bus.ledsel !== sel && g < 8 * SDIV + 8);
      chk({name, "_sel"}, 32'(bus.ledsel), 32'(sel));
      chk(name, 32'(bus.ledout), 32'(exp));
   endtask

   logic [7:0] hex_exp [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

   initial begin
      int n, seen, hold;
      logic [31:0] v;
      bus.val = '0; bus.mode = 1'b0; bus.blank_lz = 1'b0;

      // reset state
      repeat (3) tick();
      chk("rst_ledsel", 32'(bus.ledsel), 32'h00FE);
      chk("rst_ledout", 32'(bus.ledout), 32'h00C0);
      chk("rst_busy",   32'(bus.busy),   32'h0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (6) begin tick(); if (bus.busy) seen++; end
      chk("no_conv_after_reset", 32'(seen), 32'h0);

      // hex scan
      drive(32'h12345678, 1'b0);
      busy_len(n);
      chk("hex_busy_len", 32'(n), 32'd2);
      for (int i = 0; i < 8; i++) check_digit(i, hex_exp[i], $sformatf("hex_d%0d", i));

      // decimal
      drive(32'd12345678, 1'b1);
      busy_len(n);
      chk("dec_busy_len", 32'(n), 32'd33);
      check_digit(0, 8'h80, "dec_d0");
      check_digit(3, 8'h92, "dec_d3");
      check_digit(7, 8'hF9, "dec_d7");

      // overflow and largest fitting value
      drive(32'd100000000, 1'b1);
      busy_len(n);
      check_digit(0, 8'h86, "ovf_d0");
      check_digit(7, 8'h86, "ovf_d7");
      drive(32'd99999999, 1'b1);
      busy_len(n);
      check_digit(0, 8'h90, "max_d0");
      check_digit(7, 8'h90, "max_d7");

      // leading-zero blanking, evaluated live
      @(negedge clk); bus.blank_lz = 1'b1;
      drive(32'd42, 1'b1);
      busy_len(n);
      check_digit(7, 8'hFF, "blk_d7");
      check_digit(2, 8'hFF, "blk_d2");
      check_digit(1, 8'h99, "blk_d1");
      check_digit(0, 8'hA4, "blk_d0");
      drive(32'd0, 1'b1);
      busy_len(n);
      check_digit(0, 8'hC0, "zero_d0");
      check_digit(1, 8'hFF, "zero_d1");
      @(negedge clk); bus.blank_lz = 1'b0;
      check_digit(1, 8'hC0, "noblk_d1");

      // change during conversion
      drive(32'd5, 1'b1);
      repeat (10) tick();
      drive(32'd7, 1'b1);
      busy_len(n);
      tick();
      chk("second_pulse", 32'(bus.busy), 32'h1);
      check_digit(0, 8'h92, "mid_first_d0");
      busy_len(n);
      check_digit(0, 8'hF8, "mid_final_d0");

      // reset in the middle of a conversion
      drive(32'd999, 1'b1);
      repeat (14) tick();
      @(negedge clk); rst = 1'b1;
      tick();
      chk("midrst_busy",   32'(bus.busy),   32'h0);
      chk("midrst_ledsel", 32'(bus.ledsel), 32'h00FE);
      chk("midrst_ledout", 32'(bus.ledout), 32'h00C0);
      @(negedge clk); rst = 1'b0;
      tick();
      chk("restart_busy", 32'(bus.busy), 32'h1);
      busy_len(n);
      check_digit(2, 8'h90, "rst999_d2");
      check_digit(3, 8'hC0, "rst999_d3");

      // random stimulus, checked every cycle by the model
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 999);
            1:       v = 32'd99999990 + $urandom_range(0, 20);
            2:       v = $urandom;
            default: v = bus.val;
         endcase
         bus.val      = v;
         bus.mode     = 1'($urandom_range(0, 1));
         bus.blank_lz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         hold = $urandom_range(1, 45);
         repeat (hold) @(negedge clk);
      end
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
